// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NUM_CH read-latency-1 FIFOs into a single ready/valid stream.
// Each grant reads up to BURST_LEN words through a 2-entry output buffer.
module fifo_rr_drain #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         rdclk,
   input  logic                         clear,
   input  logic                         enable,
   input  logic [NUM_CH-1:0]            rdempty,
   output logic [NUM_CH-1:0]            rdreq,
   input  logic [NUM_CH*DATA_WIDTH-1:0] q,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [CH_W-1:0]              out_ch,
   output logic                         out_sop,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy
);

   localparam int EW = DATA_WIDTH + CH_W + 1;
   localparam logic [7:0] BL8 = 8'(BURST_LEN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CH_W-1:0] grant_q, grant_d;
   logic [CH_W-1:0] last_q, last_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            infl_q, infl_d;
   logic            infl_sop_q, infl_sop_d;
   logic [1:0]      bcnt_q, bcnt_d;
   logic [EW-1:0]   e0_q, e0_d;
   logic [EW-1:0]   e1_q, e1_d;

   logic                  pop_s;
   logic                  push_s;
   logic [2:0]            occ_s;
   logic                  issue_ok_s;
   logic                  issue_s;
   logic                  found_s;
   logic [CH_W-1:0]       pick_s;
   logic [CH_W-1:0]       cand_s;
   logic [DATA_WIDTH-1:0] cap_data_s;
   logic [EW-1:0]         new_s;

   assign out_valid = (bcnt_q != 2'd0);
   assign pop_s     = out_valid & out_ready;
   assign push_s    = infl_q;
   assign out_data  = e0_q[DATA_WIDTH-1:0];
   assign out_ch    = e0_q[DATA_WIDTH +: CH_W];
   assign out_sop   = e0_q[EW-1];
   assign busy      = (state_q != IDLE) | infl_q | (bcnt_q != 2'd0);

   // Occupancy after this edge must leave room for the word a new read will deliver.
   assign occ_s      = {1'b0, bcnt_q} + {2'b00, infl_q} - {2'b00, pop_s};
   assign issue_ok_s = (state_q == BURST) && (occ_s < 3'd2);
   assign issue_s    = issue_ok_s && !rdempty[grant_q];

   // Round-robin search: lowest offset from last_grant that is non-empty wins.
   always_comb begin
      found_s = 1'b0;
      pick_s  = last_q;
      cand_s  = last_q;
      for (int k = NUM_CH; k >= 1; k--) begin
         cand_s = CH_W'((int'(last_q) + k) % NUM_CH);
         if (!rdempty[cand_s]) begin
            found_s = 1'b1;
            pick_s  = cand_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Read request is only ever driven on the granted channel.
   always_comb begin
      rdreq          = {NUM_CH{1'b0}};
      rdreq[grant_q] = issue_s;
   end

   // Select the granted channel's FIFO data for capture.
   always_comb begin
      cap_data_s = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_q == CH_W'(i)) begin
            cap_data_s = q[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            cap_data_s = cap_data_s;
         end
      end
      new_s = {infl_sop_q, grant_q, cap_data_s};
   end

   // Grant FSM next state.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      infl_d     = issue_s;
      infl_sop_d = (cnt_q == 8'd0);
      case (state_q)
         IDLE: begin
            if (enable && found_s) begin
               grant_d = pick_s;
               cnt_d   = 8'd0;
               state_d = BURST;
            end else begin
               state_d = IDLE;
            end
         end
         BURST: begin
            if (issue_s) begin
               cnt_d = cnt_q + 8'd1;
               if ((cnt_q + 8'd1) == BL8) begin
                  state_d = FLUSH;
               end else begin
                  state_d = BURST;
               end
            end else if (issue_ok_s) begin
               // Room to read but the channel ran dry: end the burst early.
               state_d = FLUSH;
            end else begin
               state_d = BURST;
            end
         end
         FLUSH: begin
            if (!infl_q) begin
               state_d = IDLE;
               last_d  = grant_q;
            end else begin
               state_d = FLUSH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Two-entry output buffer; e0 is always the head so outputs come straight from flops.
   always_comb begin
      e0_d   = e0_q;
      e1_d   = e1_q;
      bcnt_d = bcnt_q;
      case (bcnt_q)
         2'd0: begin
            if (push_s) begin
               e0_d   = new_s;
               bcnt_d = 2'd1;
            end else begin
               bcnt_d = 2'd0;
            end
         end
         2'd1: begin
            if (push_s && pop_s) begin
               e0_d = new_s;
            end else if (push_s) begin
               e1_d   = new_s;
               bcnt_d = 2'd2;
            end else if (pop_s) begin
               bcnt_d = 2'd0;
            end else begin
               bcnt_d = 2'd1;
            end
         end
         2'd2: begin
            if (pop_s) begin
               e0_d = e1_q;
               if (push_s) begin
                  e1_d = new_s;
               end else begin
                  bcnt_d = 2'd1;
               end
            end else begin
               bcnt_d = 2'd2;
            end
         end
         default: begin
            bcnt_d = 2'd0;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge rdclk or posedge clear) begin
      if (clear) begin
         state_q    <= IDLE;
         grant_q    <= {CH_W{1'b0}};
         last_q     <= CH_W'(NUM_CH - 1);
         cnt_q      <= 8'd0;
         infl_q     <= 1'b0;
         infl_sop_q <= 1'b0;
         bcnt_q     <= 2'd0;
         e0_q       <= {EW{1'b0}};
         e1_q       <= {EW{1'b0}};
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         infl_q     <= infl_d;
         infl_sop_q <= infl_sop_d;
         bcnt_q     <= bcnt_d;
         e0_q       <= e0_d;
         e1_q       <= e1_d;
      end
   end

endmodule
